mult_operand_streamer: RTL and testbench
========================================

Name: mult_operand_streamer

Overview:
- Initiator for the block-serial big-number multiplier interface: a host loads operands n and m block by block into internal storage.
- On start, and once the multiplier reports ready, it streams both operands as NUM_BLOCKS back-to-back 32-bit beat pairs, least-significant block first.
- It then monitors the multiplier's result stream until the final flag, counting result beats, pulsing done, and flagging errors and timeouts.

Parameters:
- REGISTER_SIZE, 32, width of one block in bits.
- BITS_IN_NUM, 2048, operand width in bits. NUM_BLOCKS = BITS_IN_NUM/REGISTER_SIZE is a localparam.
- TIMEOUT_CYCLES, 32768, maximum cycles allowed in WAIT_RESULT before abort.

Ports:
- clk_in  input  1  clock; all logic on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- load_valid_in  input  1  write one operand block this cycle.
- load_sel_in  input  1  0 = n bank, 1 = m bank.
- load_addr_in  input  $clog2(NUM_BLOCKS)  block index; 0 = least significant.
- load_data_in  input  REGISTER_SIZE  block data.
- start_in  input  1  request a multiplication.
- ready_in  input  1  multiplier ready (idle).
- n_out  output  REGISTER_SIZE  n block to multiplier.
- m_out  output  REGISTER_SIZE  m block to multiplier.
- valid_out  output  1  n_out/m_out beat valid.
- result_valid_in  input  1  multiplier result beat valid.
- result_final_in  input  1  multiplier last-result flag.
- busy_out  output  1  high in any state other than IDLE.
- done_out  output  1  one-cycle pulse on normal completion.
- result_count_out  output  16  result_valid_in beats seen in the last run, including the final one; held until the next start.
- error_out  output  1  one-cycle pulse on illegal request or timeout.

Behaviour:
- Reset values:
  - Outputs: n_out = 0, m_out = 0, valid_out = 0, busy_out = 0, done_out = 0, error_out = 0, result_count_out = 0.
  - State: IDLE; beat index 0; timeout counter 0.
  - Operand storage is not cleared.
- Storage: two register arrays of NUM_BLOCKS x REGISTER_SIZE.
  - A load is written only in IDLE.
  - load_valid_in in any other state is ignored and pulses error_out the next cycle.
- States:
  - IDLE:
    - Accepts loads.
    - start_in = 1 -> ARM; result_count_out is cleared.
    - If load_valid_in and start_in are high in the same cycle, the load is written first, so the write is included in the run.
  - ARM:
    - Waits for ready_in = 1.
    - When ready_in is sampled high at cycle T, the state goes to STREAM and the first beat (block 0) appears at T+1.
  - STREAM:
    - valid_out is high for exactly NUM_BLOCKS consecutive cycles, carrying block k on beat k, with no gaps.
    - ready_in is ignored once streaming has begun, because the multiplier drops ready after the first beat.
    - The cycle after the last beat: valid_out = 0, n_out = 0, m_out = 0, state -> WAIT_RESULT.
  - WAIT_RESULT:
    - Each result_valid_in = 1 increments result_count_out; the count saturates at 0xFFFF.
    - A result_valid_in that coincides with result_final_in is also counted.
    - The first cycle with result_final_in = 1 -> done_out pulses for one cycle and the state returns to IDLE.
    - The timeout counter increments every cycle spent in this state. On reaching TIMEOUT_CYCLES -> error_out pulses, done_out stays low, the state returns to IDLE and result_count_out keeps its partial value.
    - Simultaneous final and timeout: final wins.
- Outputs are registered. n_out/m_out are 0 whenever valid_out = 0.
- start_in outside IDLE is ignored and pulses error_out.
  - If an illegal load and an illegal start occur in the same cycle, there is one error_out pulse.
- Result beats or final arriving outside WAIT_RESULT are ignored.
- Reset mid-operation: on the next cycle the state is IDLE and valid_out is 0. Any partial stream is abandoned; the downstream multiplier must be reset alongside.
- Latency: start accepted with ready_in already high -> first beat 2 cycles later; last beat at start + 1 + NUM_BLOCKS.

Test Plan:
- Load n[k] = k+1 and m[k] = 0x1000_0000 + k for all 64 blocks, then pulse start with ready_in = 1 -> valid_out is high for 64 contiguous cycles starting 2 cycles after start; beat k shows n_out = k+1, m_out = 0x1000_0000 + k; busy_out = 1.
- Hold ready_in = 0 for 10 cycles after start, then raise it -> no beat appears while ready_in is low; the first beat comes 1 cycle after ready_in rises. Drop ready_in after beat 0 -> all 64 beats are still sent.
- After streaming, drive 258 result_valid_in beats with result_final_in on the 258th -> done_out pulses once the next cycle, result_count_out = 258, busy_out = 0.
- Pulse load_valid_in and start_in during STREAM -> error_out pulses for one cycle; the stored block is unchanged (verified on the next run); streaming is undisturbed.
- With TIMEOUT_CYCLES = 100 and no final -> error_out pulses once 100 cycles after entering WAIT_RESULT, done_out stays 0, return to IDLE.
- Assert rst_in at beat 30 -> valid_out = 0 the next cycle and the state is IDLE. A restart then streams all 64 blocks correctly from stored contents.

Source files
------------

// File: rtl/mult_operand_streamer.sv
// mult_operand_streamer: loads two big-number operands block-wise, streams them to a block-serial multiplier and tracks its results.
module mult_operand_streamer #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM = 2048,
  parameter int TIMEOUT_CYCLES = 32768
) (
  input  logic                                               clk_in,
  input  logic                                               rst_in,
  input  logic                                               load_valid_in,
  input  logic                                               load_sel_in,
  input  logic [$clog2(BITS_IN_NUM/REGISTER_SIZE)-1:0]       load_addr_in,
  input  logic [REGISTER_SIZE-1:0]                           load_data_in,
  input  logic                                               start_in,
  input  logic                                               ready_in,
  output logic [REGISTER_SIZE-1:0]                           n_out,
  output logic [REGISTER_SIZE-1:0]                           m_out,
  output logic                                               valid_out,
  input  logic                                               result_valid_in,
  input  logic                                               result_final_in,
  output logic                                               busy_out,
  output logic                                               done_out,
  output logic [15:0]                                        result_count_out,
  output logic                                               error_out
);
  localparam int NUM_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int AW = $clog2(NUM_BLOCKS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ARM, STREAM, WAIT_RESULT} state_t;
  state_t state, state_d;
  logic [AW-1:0] idx, idx_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic [15:0] count_d;
  logic valid_d, done_d, error_d;
  logic [REGISTER_SIZE-1:0] n_mem [NUM_BLOCKS];
  logic [REGISTER_SIZE-1:0] m_mem [NUM_BLOCKS];
  // operand storage is deliberately left out of reset
  always_ff @(posedge clk_in) begin
    if (load_valid_in && state == IDLE && load_sel_in) m_mem[load_addr_in] <= load_data_in;
    if (load_valid_in && state == IDLE && !load_sel_in) n_mem[load_addr_in] <= load_data_in;
  end
  always_comb begin
    state_d = state;
    idx_d = idx;
    tcnt_d = tcnt;
    count_d = result_count_out;
    valid_d = 1'b0;
    done_d = 1'b0;
    error_d = state != IDLE && (load_valid_in || start_in);
    case (state)
      IDLE: begin
        state_d = start_in ? ARM : IDLE;
        count_d = start_in ? '0 : result_count_out;
      end
      ARM: begin
        state_d = ready_in ? STREAM : ARM;
        idx_d = '0;
        valid_d = ready_in;
      end
      STREAM: begin
        state_d = idx == AW'(NUM_BLOCKS - 1) ? WAIT_RESULT : STREAM;
        valid_d = idx != AW'(NUM_BLOCKS - 1);
        idx_d = valid_d ? idx + 1'b1 : idx;
      end
      WAIT_RESULT: begin
        count_d = result_valid_in && result_count_out != 16'hFFFF ? result_count_out + 1'b1 : result_count_out;
        tcnt_d = tcnt + 1'b1;
        // a final arriving on the timeout cycle still counts as normal completion
        done_d = result_final_in;
        error_d = error_d || (!result_final_in && tcnt_d == TW'(TIMEOUT_CYCLES));
        state_d = result_final_in || tcnt_d == TW'(TIMEOUT_CYCLES) ? IDLE : WAIT_RESULT;
        tcnt_d = state_d == IDLE ? '0 : tcnt_d;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      idx <= '0;
      tcnt <= '0;
      valid_out <= 1'b0;
      n_out <= '0;
      m_out <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      error_out <= 1'b0;
      result_count_out <= '0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      tcnt <= tcnt_d;
      valid_out <= valid_d;
      n_out <= valid_d ? n_mem[idx_d] : '0;
      m_out <= valid_d ? m_mem[idx_d] : '0;
      busy_out <= state_d != IDLE;
      done_out <= done_d;
      error_out <= error_d;
      result_count_out <= count_d;
    end
  end
endmodule

// File: tb/tb_mult_operand_streamer.sv
// tb_mult_operand_streamer: randomized scenario bench with an array-based operand model.
module tb_mult_operand_streamer;
  localparam int NB = 64;
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  logic rst_in, load_valid_in, load_sel_in, start_in, ready_in, result_valid_in, result_final_in;
  logic [5:0] load_addr_in;
  logic [31:0] load_data_in, n_out, m_out, n2, m2;
  logic valid_out, busy_out, done_out, error_out;
  logic [15:0] result_count_out, cnt2;
  logic start2, ready2, rv2, valid2, busy2, done2, error2;
  logic [31:0] n_ref [NB];
  logic [31:0] m_ref [NB];
  int checks = 0;
  int errors = 0;

  mult_operand_streamer dut (
    .clk_in(clk_in), .rst_in(rst_in), .load_valid_in(load_valid_in), .load_sel_in(load_sel_in),
    .load_addr_in(load_addr_in), .load_data_in(load_data_in), .start_in(start_in), .ready_in(ready_in),
    .n_out(n_out), .m_out(m_out), .valid_out(valid_out), .result_valid_in(result_valid_in),
    .result_final_in(result_final_in), .busy_out(busy_out), .done_out(done_out),
    .result_count_out(result_count_out), .error_out(error_out)
  );

  mult_operand_streamer #(.TIMEOUT_CYCLES(100)) dut_to (
    .clk_in(clk_in), .rst_in(rst_in), .load_valid_in(1'b0), .load_sel_in(1'b0),
    .load_addr_in(6'd0), .load_data_in(32'd0), .start_in(start2), .ready_in(ready2),
    .n_out(n2), .m_out(m2), .valid_out(valid2), .result_valid_in(rv2),
    .result_final_in(1'b0), .busy_out(busy2), .done_out(done2),
    .result_count_out(cnt2), .error_out(error2)
  );

  task automatic step;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    step;
    step;
    rst_in = 1'b0;
    checks++;
    if ({valid_out, busy_out, done_out, error_out} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {valid_out, busy_out, done_out, error_out});
    end
    checks++;
    if ({n_out, m_out} !== 64'd0) begin
      errors++;
      $display("FAIL reset_data got n=%h m=%h want 0", n_out, m_out);
    end
    checks++;
    if (result_count_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_count got %0d want 0", result_count_out);
    end
    checks++;
    if ({valid2, busy2, done2, error2, cnt2} !== 20'd0) begin
      errors++;
      $display("FAIL reset_dut_to got %b want 0", {valid2, busy2, done2, error2, cnt2});
    end
  endtask

  task automatic load_all;
    for (int k = 0; k < NB; k++) begin
      load_valid_in = 1'b1;
      load_addr_in = 6'(k);
      load_sel_in = 1'b0;
      load_data_in = 32'(k + 1);
      n_ref[k] = 32'(k + 1);
      step;
      load_sel_in = 1'b1;
      load_data_in = 32'h1000_0000 + 32'(k);
      m_ref[k] = 32'h1000_0000 + 32'(k);
      step;
    end
    load_valid_in = 1'b0;
  endtask

  task automatic test_reload;
    int a;
    logic s;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      a = int'($urandom_range(0, NB - 1));
      s = 1'($urandom);
      d = $urandom;
      load_valid_in = 1'b1;
      load_sel_in = s;
      load_addr_in = 6'(a);
      load_data_in = d;
      if (s) m_ref[a] = d;
      else n_ref[a] = d;
      step;
      checks++;
      if (error_out !== 1'b0) begin
        errors++;
        $display("FAIL idle_load_error got %b want 0", error_out);
      end
    end
    load_valid_in = 1'b0;
  endtask

  task automatic test_stream(input int rdy_delay, input bit drop, input bit illegal, input int rst_beat, input bit coload);
    int a;
    logic s;
    logic [31:0] d;
    ready_in = rdy_delay == 0;
    start_in = 1'b1;
    if (coload) begin
      a = int'($urandom_range(0, NB - 1));
      s = 1'($urandom);
      d = $urandom;
      load_valid_in = 1'b1;
      load_sel_in = s;
      load_addr_in = 6'(a);
      load_data_in = d;
      if (s) m_ref[a] = d;
      else n_ref[a] = d;
    end
    step;
    start_in = 1'b0;
    load_valid_in = 1'b0;
    checks++;
    if ({valid_out, busy_out, error_out, result_count_out} !== {3'b010, 16'd0}) begin
      errors++;
      $display("FAIL arm got valid=%b busy=%b err=%b cnt=%0d want 0 1 0 0", valid_out, busy_out, error_out, result_count_out);
    end
    for (int i = 0; i < rdy_delay; i++) begin
      step;
      checks++;
      if ({valid_out, busy_out} !== 2'b01) begin
        errors++;
        $display("FAIL wait_ready cycle %0d got valid=%b busy=%b want 0 1", i, valid_out, busy_out);
      end
    end
    ready_in = 1'b1;
    step;
    for (int k = 0; k < NB; k++) begin
      checks++;
      if ({valid_out, busy_out, n_out, m_out} !== {2'b11, n_ref[k], m_ref[k]}) begin
        errors++;
        $display("FAIL beat %0d got v=%b b=%b n=%h m=%h want 1 1 %h %h", k, valid_out, busy_out, n_out, m_out, n_ref[k], m_ref[k]);
      end
      checks++;
      if (error_out !== (illegal && k == 11)) begin
        errors++;
        $display("FAIL stream_error beat %0d got %b want %b", k, error_out, illegal && k == 11);
      end
      if (drop) ready_in = 1'b0;
      if (illegal && k == 10) begin
        load_valid_in = 1'b1;
        load_sel_in = 1'($urandom);
        load_addr_in = 6'($urandom);
        load_data_in = $urandom;
        start_in = 1'b1;
      end
      if (k == rst_beat) begin
        rst_in = 1'b1;
        step;
        rst_in = 1'b0;
        ready_in = 1'b0;
        checks++;
        if ({valid_out, busy_out, n_out, m_out, result_count_out} !== 82'd0) begin
          errors++;
          $display("FAIL mid_reset got v=%b b=%b n=%h m=%h cnt=%0d want all 0", valid_out, busy_out, n_out, m_out, result_count_out);
        end
        return;
      end
      step;
      load_valid_in = 1'b0;
      start_in = 1'b0;
    end
    ready_in = 1'b0;
    checks++;
    if ({valid_out, busy_out, n_out, m_out} !== {2'b01, 64'd0}) begin
      errors++;
      $display("FAIL stream_end got v=%b b=%b n=%h m=%h want 0 1 0 0", valid_out, busy_out, n_out, m_out);
    end
  endtask

  task automatic test_results(input int nb, input bit gaps, input bit final_alone);
    int sent;
    sent = 0;
    while (sent < nb) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        result_valid_in = 1'b0;
        result_final_in = 1'b0;
      end else begin
        sent++;
        result_valid_in = 1'b1;
        result_final_in = sent == nb && !final_alone;
      end
      step;
      if (!result_final_in) begin
        checks++;
        if ({result_count_out, done_out, busy_out} !== {16'(sent), 2'b01}) begin
          errors++;
          $display("FAIL result_progress got cnt=%0d done=%b busy=%b want %0d 0 1", result_count_out, done_out, busy_out, sent);
        end
      end
    end
    if (final_alone) begin
      result_valid_in = 1'b0;
      result_final_in = 1'b1;
      step;
    end
    checks++;
    if ({result_count_out, done_out, busy_out, error_out} !== {16'(nb), 3'b100}) begin
      errors++;
      $display("FAIL result_done got cnt=%0d done=%b busy=%b err=%b want %0d 1 0 0", result_count_out, done_out, busy_out, error_out, nb);
    end
    result_valid_in = 1'b1;
    result_final_in = 1'b1;
    step;
    result_valid_in = 1'b0;
    result_final_in = 1'b0;
    checks++;
    if ({result_count_out, done_out, busy_out} !== {16'(nb), 2'b00}) begin
      errors++;
      $display("FAIL idle_result_ignored got cnt=%0d done=%b busy=%b want %0d 0 0", result_count_out, done_out, busy_out, nb);
    end
  endtask

  task automatic test_timeout;
    start2 = 1'b1;
    ready2 = 1'b1;
    step;
    start2 = 1'b0;
    for (int i = 0; i < NB + 1; i++) step;
    ready2 = 1'b0;
    checks++;
    if ({valid2, busy2} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_enter got v=%b b=%b want 0 1", valid2, busy2);
    end
    rv2 = 1'b1;
    for (int i = 0; i < 5; i++) step;
    rv2 = 1'b0;
    for (int i = 5; i < 99; i++) begin
      step;
      checks++;
      if ({error2, done2, busy2} !== 3'b001) begin
        errors++;
        $display("FAIL timeout_wait cycle %0d got err=%b done=%b busy=%b want 0 0 1", i, error2, done2, busy2);
      end
    end
    step;
    checks++;
    if ({error2, done2, busy2, cnt2} !== {3'b100, 16'd5}) begin
      errors++;
      $display("FAIL timeout_fire got err=%b done=%b busy=%b cnt=%0d want 1 0 0 5", error2, done2, busy2, cnt2);
    end
    step;
    checks++;
    if ({error2, done2, busy2} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_after got err=%b done=%b busy=%b want 0 0 0", error2, done2, busy2);
    end
  endtask

  initial begin
    {rst_in, load_valid_in, load_sel_in, start_in, ready_in, result_valid_in, result_final_in} = '0;
    {start2, ready2, rv2} = '0;
    load_addr_in = '0;
    load_data_in = '0;
    test_reset;
    load_all;
    test_stream(0, 0, 0, -1, 0);
    test_results(258, 0, 0);
    test_stream(10, 1, 0, -1, 0);
    test_results(int'($urandom_range(1, 40)), 1, 0);
    test_reload;
    test_stream(0, 1, 1, -1, 0);
    test_results(int'($urandom_range(1, 40)), 1, 1);
    test_stream(3, 0, 0, -1, 0);
    test_results(5, 0, 0);
    test_stream(0, 0, 0, 30, 0);
    test_stream(0, 0, 0, -1, 1);
    test_results(int'($urandom_range(1, 40)), 1, 0);
    test_timeout;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
